// File: rtl/vdf_seq_pkg.sv
// Shared types and default widths for the VDF squaring sequencer.
// No logic, so no latency.
// No flow control of its own.
package vdf_seq_pkg;

    localparam int DEF_T_BITS         = 64;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/sq_repack.sv
// Takes the low WORD_LEN bits of each 2*WORD_LEN squarer slot and packs them into a dense value.
// Purely combinational, zero latency.
// No flow control.
module sq_repack #(
    parameter int WORD_LEN     = 16,
    parameter int NUM_ELEMENTS = 64
) (
    input  logic [NUM_ELEMENTS*WORD_LEN*2-1:0] sq_out,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0]   x
);

    // Upper slot halves carry carries the squarer has already folded; they are dropped.
    logic [NUM_ELEMENTS*WORD_LEN-1:0] unused_hi;

    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_slot
        assign x[j*WORD_LEN +: WORD_LEN]         = sq_out[j*2*WORD_LEN +: WORD_LEN];
        assign unused_hi[j*WORD_LEN +: WORD_LEN] = sq_out[j*2*WORD_LEN+WORD_LEN +: WORD_LEN];
    end

endmodule

// File: rtl/vdf_squaring_sequencer.sv
// Runs T back-to-back modular squarings through an external squarer; optional watchdog under SEQ_TIMEOUT_EN.
// Latency: accept->first sq_start 1 cycle; per iteration squarer latency + 1; last sq_valid->res_valid 1 cycle.
// Backpressure: one command in flight; result held in DONE until res_ready, cmd_ready only in IDLE.
module vdf_squaring_sequencer
    import vdf_seq_pkg::*;
#(
    parameter int MOD_LEN        = 1024,
    parameter int WORD_LEN       = 16,
    parameter int NUM_ELEMENTS   = MOD_LEN / WORD_LEN,
    parameter int SQ_OUT_BITS    = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int T_BITS         = DEF_T_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [MOD_LEN-1:0]     cmd_x,
    input  logic [T_BITS-1:0]      cmd_t,
    input  logic                   abort,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [MOD_LEN-1:0]     res_y,
    output logic [T_BITS-1:0]      res_iters,
    output logic                   busy,
    output logic                   error
);

    seq_state_t          state, state_nxt;
    logic [MOD_LEN-1:0]  x_q, x_sq;
    logic [T_BITS-1:0]   count_q, target_q;
    logic                outstanding_q;
    logic                accept, take, last, wd_hit;

    sq_repack #(
        .WORD_LEN     (WORD_LEN),
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_repack (
        .sq_out (sq_out),
        .x      (x_sq)
    );

    // A result only counts while one is actually owed to us.
    assign take = sq_valid && outstanding_q && (state == S_WAIT || state == S_DRAIN);
    assign last = (count_q + T_BITS'(1)) == target_q;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            error_q;

    assign wd_hit = (state == S_WAIT || state == S_DRAIN) && !take &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign error  = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wd_q <= '0;
            else if (state == S_WAIT || state == S_DRAIN)
                wd_q <= wd_q + WD_W'(1);
            if (accept)
                error_q <= 1'b0;
            else if (wd_hit)
                error_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign wd_hit = 1'b0;
    assign error  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_t == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = abort ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                // A result landing with abort still completes its iteration.
                if (take)        state_nxt = last ? S_DONE : (abort ? S_DRAIN : S_ISSUE);
                else if (wd_hit) state_nxt = S_DONE;
                else if (abort)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (take || wd_hit || !outstanding_q) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q           <= '0;
            count_q       <= '0;
            target_q      <= '0;
            outstanding_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q      <= cmd_x;
                target_q <= cmd_t;
                count_q  <= '0;
            end else if (take && state == S_WAIT) begin
                x_q     <= x_sq;
                count_q <= count_q + T_BITS'(1);
            end
            if (state == S_ISSUE)
                outstanding_q <= 1'b1;
            else if (take || wd_hit)
                outstanding_q <= 1'b0;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign sq_start  = (state == S_ISSUE);
    assign sq_in     = x_q;
    assign res_valid = (state == S_DONE);
    assign res_y     = x_q;
    assign res_iters = count_q;

endmodule

// File: tb/tb_vdf_squaring_sequencer.sv
// Directed bench: behavioural x^2 mod N squarer with fixed latency 8 feeding the sequencer.
module tb_vdf_squaring_sequencer;

    localparam int ML  = 1024;
    localparam int NE  = 64;
    localparam int SQB = NE * 16 * 2;
    localparam int TB  = 64;
    localparam int LAT = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [ML-1:0]   cmd_x = '0;
    logic [TB-1:0]   cmd_t = '0;
    logic            abort = 1'b0;
    logic            sq_start;
    logic [ML-1:0]   sq_in;
    logic [SQB-1:0]  sq_out = '0;
    logic            sq_valid = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [ML-1:0]   res_y;
    logic [TB-1:0]   res_iters;
    logic            busy;
    logic            error;

    vdf_squaring_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_t     (cmd_t),
        .abort     (abort),
        .sq_start  (sq_start),
        .sq_in     (sq_in),
        .sq_out    (sq_out),
        .sq_valid  (sq_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_iters (res_iters),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [ML-1:0] got, input logic [ML-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Squarer model and monitors share one process so the bench sees a settled view.
    logic [2047:0] modn;
    initial modn = (2048'd1 << 1023) + 2048'd12345;

    function automatic logic [ML-1:0] model_sq(input logic [ML-1:0] v);
        logic [2047:0] w;
        w = {1024'd0, v} * {1024'd0, v};
        w = w % modn;
        return w[ML-1:0];
    endfunction

    function automatic logic [SQB-1:0] model_pack(input logic [ML-1:0] v);
        logic [SQB-1:0] s;
        for (int j = 0; j < NE; j++) begin
            s[j*32 +: 16]      = v[j*16 +: 16];
            s[j*32 + 16 +: 16] = 16'hDEAD ^ 16'(j);
        end
        return s;
    endfunction

    logic          mute = 1'b0;
    logic          pend = 1'b0;
    int            mcnt = 0;
    logic [ML-1:0] cap = '0;
    int            n_start = 0;
    int            start_cyc[64];
    int            rise_cyc = 0;
    logic          res_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            pend     = 1'b0;
            sq_valid = 1'b0;
            mcnt     = 0;
        end else begin
            sq_valid = 1'b0;
            if (pend) begin
                mcnt--;
                if (mcnt == 0) begin
                    pend     = 1'b0;
                    sq_valid = 1'b1;
                    sq_out   = model_pack(model_sq(cap));
                end
            end
            if (sq_start && !mute) begin
                pend = 1'b1;
                mcnt = LAT;
                cap  = sq_in;
            end
        end
        if (sq_start) begin
            start_cyc[n_start % 64] = cyc;
            n_start++;
        end
        if (res_valid && !res_prev) rise_cyc = cyc;
        res_prev = res_valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int acc = 0;

    task automatic send(input logic [ML-1:0] x, input logic [TB-1:0] t);
        cmd_valid = 1'b1;
        cmd_x     = x;
        cmd_t     = t;
        acc       = cyc;
        step();
        cmd_valid = 1'b0;
        chk("err_clr_on_accept", error, 0);
    endtask

    task automatic wait_res(input int budget);
        int k;
        k = 0;
        while (!res_valid && k < budget) begin
            step();
            k++;
        end
        if (!res_valid) chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_fall", res_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    logic [ML-1:0] exp_big;
    int base;

    initial begin
        exp_big = (1024'd1 << 64) | (1024'd1 << 50) | (1024'd1 << 34) |
                  (1024'd1 << 33) | (1024'd1 << 18) | 1024'd1;

        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_sq_start", sq_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_sq_in", sq_in, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_iters", res_iters, 0);
        reset = 1'b1;
        step();

        // x=3, T=1
        base = n_start;
        send(3, 1);
        chk("t1_busy", busy, 1);
        wait_res(100);
        chk("t1_starts", n_start - base, 1);
        chk("t1_first_start", start_cyc[base % 64] - acc, 1);
        chk("t1_res_lat", rise_cyc - start_cyc[base % 64], 9);
        chk("t1_res_y", res_y, 9);
        chk("t1_res_iters", res_iters, 1);
        chk("t1_error", error, 0);
        handshake();

        // x=3, T=3
        base = n_start;
        send(3, 3);
        wait_res(200);
        chk("t3_starts", n_start - base, 3);
        chk("t3_gap1", start_cyc[(base + 1) % 64] - start_cyc[base % 64], 9);
        chk("t3_gap2", start_cyc[(base + 2) % 64] - start_cyc[(base + 1) % 64], 9);
        chk("t3_res_lat", rise_cyc - start_cyc[(base + 2) % 64], 9);
        chk("t3_res_y", res_y, 6561);
        chk("t3_res_iters", res_iters, 3);
        handshake();

        // x=5, T=0
        base = n_start;
        send(5, 0);
        chk("t0_res_valid", res_valid, 1);
        chk("t0_res_lat", rise_cyc - acc, 1);
        chk("t0_starts", n_start - base, 0);
        chk("t0_res_y", res_y, 5);
        chk("t0_res_iters", res_iters, 0);
        handshake();

        // abort during the 4th WAIT
        base = n_start;
        send(3, 10);
        for (int k = 0; k < 300 && n_start < base + 4; k++) step();
        chk("ab_reach_4th", (n_start - base) >= 4, 1);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_no_res_yet", res_valid, 0);
        wait_res(100);
        chk("ab_starts", n_start - base, 4);
        chk("ab_res_iters", res_iters, 3);
        chk("ab_res_y", res_y, 6561);
        handshake();
        base = n_start;
        send(2, 1);
        wait_res(100);
        chk("ab_next_starts", n_start - base, 1);
        chk("ab_next_res_y", res_y, 4);
        chk("ab_next_iters", res_iters, 1);
        handshake();

        // multi-coefficient result held under backpressure
        send(1024'h10001, 2);
        wait_res(200);
        for (int k = 0; k < 20; k++) begin
            chk("st_res_valid", res_valid, 1);
            chk("st_res_y", res_y, exp_big);
            chk("st_res_iters", res_iters, 2);
            chk("st_cmd_ready", cmd_ready, 0);
            step();
        end
        handshake();

`ifdef SEQ_TIMEOUT_EN
        mute = 1'b1;
        base = n_start;
        send(7, 5);
        wait_res(1200);
        chk("wd_error", error, 1);
        chk("wd_res_iters", res_iters, 0);
        chk("wd_res_y", res_y, 7);
        chk("wd_lat", rise_cyc - start_cyc[base % 64], 1025);
        handshake();
        chk("wd_error_sticky", error, 1);
        mute = 1'b0;
        send(2, 1);
        wait_res(100);
        chk("wd_next_res_y", res_y, 4);
        handshake();
`else
        chk("no_wd_error", error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
